// File: rtl/vga_pkg.sv
// Shared VGA timing constants and types for the sync generator and the
// per-frame logo motion path.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int COORD_W  = 10;

  typedef enum logic {
    DIR_INC = 1'b0,
    DIR_DEC = 1'b1
  } dir_t;

endpackage

// File: rtl/bounce_axis.sv
// One axis of the bouncing-logo motion: position register, direction and
// reflection at 0 / MAX. hit is combinational and valid in the tick cycle.
module bounce_axis
  import vga_pkg::*;
#(
  parameter int MAX  = 512,
  parameter int STEP = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  output logic [9:0] pos,
  output logic       dir,
  output logic       hit
);

  localparam logic [COORD_W:0]   MAX_X  = (COORD_W+1)'(MAX);
  localparam logic [COORD_W:0]   STEP_X = (COORD_W+1)'(STEP);
  localparam logic [COORD_W-1:0] MAX_P  = COORD_W'(MAX);
  localparam logic [COORD_W-1:0] STEP_P = COORD_W'(STEP);

  dir_t             dir_q;
  logic [COORD_W:0] pos_ext;
  logic [COORD_W:0] pos_inc;
  logic             at_edge;

  // Widened by one bit so pos + STEP near MAX cannot wrap before the compare.
  assign pos_ext = {1'b0, pos};
  assign pos_inc = pos_ext + STEP_X;

  always_comb begin
    at_edge = 1'b0;
    if (dir_q == DIR_INC) at_edge = (pos_inc >= MAX_X);
    else                  at_edge = (pos_ext <= STEP_X);
  end

  assign hit = tick & at_edge;
  assign dir = dir_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos   <= '0;
      dir_q <= DIR_INC;
    end else if (tick) begin
      if (at_edge) begin
        pos   <= (dir_q == DIR_INC) ? MAX_P : '0;
        dir_q <= (dir_q == DIR_INC) ? DIR_DEC : DIR_INC;
      end else if (dir_q == DIR_INC) begin
        pos <= pos_inc[COORD_W-1:0];
      end else begin
        pos <= pos - STEP_P;
      end
    end
  end

endmodule

// File: rtl/logo_bouncer.sv
// Per-frame logo motion controller: frame strobe decode, wall-hit events,
// palette index counter and the registered logo-relative coordinate path.
module logo_bouncer
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int LOGO_W   = 128,
  parameter int LOGO_H   = 128,
  parameter int STEP     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       display_on,
  input  logic       pause,
  output logic [9:0] logo_x,
  output logic [9:0] logo_y,
  output logic       in_logo,
  output logic [2:0] color_index,
  output logic       bounce,
  output logic       corner
);

  localparam int                 XMAX        = H_ACTIVE - LOGO_W;
  localparam int                 YMAX        = V_ACTIVE - LOGO_H;
  localparam logic [COORD_W-1:0] STROBE_LINE = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W:0]   LOGO_W_X    = (COORD_W+1)'(LOGO_W);
  localparam logic [COORD_W:0]   LOGO_H_X    = (COORD_W+1)'(LOGO_H);
  localparam logic [2:0]         COLOR_RST   = 3'd6;

  logic             strobe;
  logic             tick;
  logic [9:0]       pos_x;
  logic [9:0]       pos_y;
  logic             dir_x;
  logic             dir_y;
  logic             hit_x;
  logic             hit_y;
  logic             inside_x;
  logic             inside_y;
  logic             unused_dirs;

  // First blanking line: position never moves while pixels are on screen.
  assign strobe = (hpos == '0) && (vpos == STROBE_LINE);
  assign tick   = strobe & ~pause;

  bounce_axis #(
    .MAX  (XMAX),
    .STEP (STEP)
  ) u_axis_x (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .pos   (pos_x),
    .dir   (dir_x),
    .hit   (hit_x)
  );

  bounce_axis #(
    .MAX  (YMAX),
    .STEP (STEP)
  ) u_axis_y (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .pos   (pos_y),
    .dir   (dir_y),
    .hit   (hit_y)
  );

  assign unused_dirs = &{1'b0, dir_x, dir_y};

  assign inside_x = ({1'b0, hpos} >= {1'b0, pos_x}) &&
                    ({1'b0, hpos} <  ({1'b0, pos_x} + LOGO_W_X));
  assign inside_y = ({1'b0, vpos} >= {1'b0, pos_y}) &&
                    ({1'b0, vpos} <  ({1'b0, pos_y} + LOGO_H_X));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      logo_x  <= '0;
      logo_y  <= '0;
      in_logo <= 1'b0;
    end else begin
      logo_x  <= hpos - pos_x;
      logo_y  <= vpos - pos_y;
      in_logo <= display_on & inside_x & inside_y;
    end
  end

  // A corner is still a single colour step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bounce      <= 1'b0;
      corner      <= 1'b0;
      color_index <= COLOR_RST;
    end else begin
      bounce <= hit_x | hit_y;
      corner <= hit_x & hit_y;
      if (hit_x | hit_y) color_index <= color_index + 3'd1;
    end
  end

endmodule

// File: doc/logo_bouncer.md
# logo_bouncer

Per-frame motion controller between the VGA sync generator and the bitmap/palette stage. It holds the logo's top-left screen position, moves it diagonally by a fixed step once per frame, and reflects it off the screen edges. From each raster position it produces logo-relative coordinates and an inside-logo flag for the bitmap ROM. On every wall hit it advances a 3-bit palette index.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- LOGO_W, 128, logo width in pixels
- LOGO_H, 128, logo height in pixels
- STEP, 1, pixels moved per frame per axis (1..15)

Ports:
- clk  in  1  pixel clock; one clock domain, no other clocks
- reset  in  1  asynchronous, active-high; all state clears immediately
- hpos  in  10  current raster column, from the sync generator
- vpos  in  10  current raster line, from the sync generator
- display_on  in  1  active-video flag from the sync generator
- pause  in  1  when 1, position is frozen at frame updates
- logo_x  out  10  hpos − pos_x, registered; reset 0
- logo_y  out  10  vpos − pos_y, registered; reset 0
- in_logo  out  1  registered; 1 when the pixel is inside the logo rectangle and display_on is 1; reset 0
- color_index  out  3  palette index; reset 3'd6
- bounce  out  1  one-cycle pulse on a frame update with any wall hit; reset 0
- corner  out  1  one-cycle pulse when both axes hit on the same update; reset 0

## Operation
- Internal state:
  - pos_x in 0..XMAX, where XMAX = H_ACTIVE − LOGO_W (512)
  - pos_y in 0..YMAX, where YMAX = V_ACTIVE − LOGO_H (352)
  - dir_x and dir_y, each 0 = increasing, 1 = decreasing
- Reset state: pos_x = pos_y = 0, dir_x = dir_y = 0, color_index = 6.
- Frame strobe asserts on the cycle where hpos == 0 and vpos == V_ACTIVE. This is the first blanking line, so the position never changes during visible scan-out.
- Per-axis update on the strobe when pause = 0:
  - Increasing: if pos + STEP ≥ MAX, then pos = MAX, dir flips to decreasing, and the axis hits. Otherwise pos += STEP.
  - Decreasing: if pos ≤ STEP, then pos = 0, dir flips to increasing, and the axis hits. Otherwise pos −= STEP.
  - Landing exactly on a boundary counts as a hit on that same update (clamp and flip together).
- Arithmetic uses 11-bit unsigned intermediates, so values never wrap. Results are clamped to 0..MAX.
- Hit handling on a frame update:
  - Any axis hit: bounce = 1 for one cycle, and color_index increments modulo 8 (7 → 0).
  - Both axes hit: corner = 1 as well, and color_index still increments by exactly 1.
- pause = 1 at the strobe: no position, direction or colour change, and no pulses.
- Coordinate path, registered every cycle:
  - logo_x = hpos − pos_x and logo_y = vpos − pos_y, modulo 2^10.
  - in_logo = display_on & (pos_x ≤ hpos < pos_x + LOGO_W) & (pos_y ≤ vpos < pos_y + LOGO_H).
- Reset asserted mid-frame: outputs return to their reset values at once. After release, the next strobe produces the first move.

## Timing
- Coordinate-path latency: 1 cycle. logo_x, logo_y and in_logo in cycle n+1 reflect hpos and vpos in cycle n.
  - The consumer adds one register stage to hsync and vsync so they stay aligned with the pixel data.
- Frame update: pos, dir and color_index change in the cycle after the strobe cycle. bounce and corner are high during that same cycle only.
- Rate: at most one update per frame. An update cannot occur during active video.

## Structure
- Shared package vga_pkg holds H_ACTIVE, V_ACTIVE and the 10-bit coordinate width. The sync generator and this block both import it.
- One sub-module, bounce_axis, instantiated twice (X and Y):
  - Parameters: MAX, STEP.
  - Inputs: clk, reset, tick.
  - Outputs: pos, dir, hit.
- The top level holds the strobe decode, hit combination, colour counter and coordinate registers.

## Test plan
- Reset → first strobe (pause = 0): all outputs at reset values before the strobe; one cycle after it, pos_x = 1 and pos_y = 1 with no bounce.
- Force pos_x = 511, dir_x = 0, then strobe → pos_x = 512, dir_x = 1, bounce pulse, color_index 6 → 7. The next hit takes it 7 → 0.
- Corner: pos_x = 511 and pos_y = 351, both increasing, then strobe → both clamp, corner = 1, bounce = 1, color_index increments by exactly 1.
- pause = 1 across 3 strobes → pos, dir and color_index unchanged; bounce stays 0.
- With pos = (100, 50), sweep hpos 99..228 on vpos 50 with display_on = 1 → in_logo is 1 for hpos 100..227 (one cycle later), logo_x 0..127, logo_y 0. With display_on = 0, in_logo is 0.
- Assert reset mid-line after several moves → outputs reset asynchronously; after release, no move until the next hpos = 0, vpos = 480.
